// File: rtl/hazard_control_unit.sv
// Load-use / branch hazard controller for the ID stage with a multi-cycle stall FSM.
// Optional HAZARD_STALL_COUNT_EN adds a saturating bubble counter output stall_count.
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ZERO_REG_EXEMPT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_rt,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  ID_uses_rt,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  IFID_write,
    output logic                  IFID_flush,
    output logic                  nop_control,
    output logic                  stall_busy
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    generate
        if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_lsc
            $error("hazard_control_unit: LOAD_STALL_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [3:0] INIT_CNT = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rt_exempt;
    logic       hazard;

    assign rt_exempt = (ZERO_REG_EXEMPT != 0) && (EX_rt == '0);
    assign hazard    = EX_MemRead && !rt_exempt &&
                       ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        nop_control = 1'b0;
        stall_busy  = (state_q == STALL);
        if (branch_taken) begin
            IFID_flush  = 1'b1;
            nop_control = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else if (state_q == STALL) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            nop_control = 1'b1;
            cnt_d       = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (hazard) begin
            // The detecting cycle is the first bubble; STALL covers the remainder.
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            nop_control = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = INIT_CNT;
            end
        end
        if (rst) begin
            pc_write    = 1'b1;
            IFID_write  = 1'b1;
            IFID_flush  = 1'b0;
            nop_control = 1'b0;
            stall_busy  = 1'b0;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    // Counts load-use bubbles only; branch flush bubbles are excluded.
    always_comb begin
        stall_count_d = stall_count_q;
        if (nop_control && !branch_taken && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule
